// File: rtl/encoder42_low_evt.sv
// Registered 4-to-2 encoder for active-low request lines. Each pattern must be stable
// before it is accepted, and each accepted non-idle pattern emits one valid/ready code event.
module encoder42_low_evt #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] y_n,
  input  logic       out_ready,
  input  logic       ovr_clr,
  output logic       out_valid,
  output logic [1:0] out_code,
  output logic       out_err,
  output logic       held,
  output logic       ovr
);

  localparam int unsigned Y_W    = 4;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned NLOW_W = 3;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [Y_W-1:0]   IDLE     = '1;

  logic [Y_W-1:0]    y_q;
  logic [Y_W-1:0]    acc;
  logic [CNT_W-1:0]  cnt;
  logic              acc_stb;

  logic [CODE_W-1:0] enc_code;
  logic [NLOW_W-1:0] n_low;
  logic              enc_multi;
  logic              ev;
  logic              ev_load;
  logic              ev_drop;

  // Classify the accepted pattern: the highest low index wins, and more than one low line flags an error.
  always_comb begin
    enc_code = '0;
    n_low    = '0;
    for (int i = 0; i < int'(Y_W); i++) begin
      if (!acc[i]) begin
        enc_code = CODE_W'(i);
        n_low    = n_low + NLOW_W'(1);
      end
    end
    enc_multi = (n_low > NLOW_W'(1));
    ev        = acc_stb && (acc != IDLE);
    ev_load   = ev && (!out_valid || out_ready);
    ev_drop   = ev && out_valid && !out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= IDLE;
      acc       <= IDLE;
      cnt       <= '0;
      acc_stb   <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_err   <= 1'b0;
      held      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      y_q <= y_n;

      // Stability filter: restart on any change, saturate once the window is full.
      if (y_n != y_q) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      acc_stb <= 1'b0;
      if ((y_n == y_q) && (cnt == CNT_LAST) && (y_q != acc)) begin
        acc     <= y_q;
        acc_stb <= 1'b1;
      end

      if (acc_stb) begin
        held <= (acc != IDLE);
      end

      // A load may coincide with the transfer of the previous event.
      if (ev_load) begin
        out_valid <= 1'b1;
        out_code  <= enc_code;
        out_err   <= enc_multi;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (ev_drop) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder42_low_evt.sv
// Self-checking bench for encoder42_low_evt. Directed scenarios and random stimulus
// are compared against a window-based reference model of acceptance and handshake.
module tb_encoder42_low_evt;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] y_n;
  logic       out_ready;
  logic       ovr_clr;
  logic       out_valid;
  logic [1:0] out_code;
  logic       out_err;
  logic       held;
  logic       ovr;

  int n_chk  = 0;
  int n_pass = 0;

  encoder42_low_evt #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .y_n(y_n), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_valid(out_valid), .out_code(out_code), .out_err(out_err), .held(held), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // Reference model: a pattern is accepted once the last S+1 sampled values agree and differ from the last accepted one.
  logic [3:0] hist[$];
  logic [3:0] m_acc, m_pat;
  logic       m_pend, m_valid, m_err, m_held, m_ovr;
  logic [1:0] m_code;

  function automatic logic [1:0] hi_low(input logic [3:0] p);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (!p[i]) r = 2'(i);
    return r;
  endfunction

  function automatic int cnt_low(input logic [3:0] p);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!p[i]) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    logic load, drop, same;
    if (rst) begin
      hist.delete();
      hist.push_back(4'hF);
      m_acc = 4'hF; m_pat = 4'hF; m_pend = 1'b0;
      m_valid = 1'b0; m_code = 2'd0; m_err = 1'b0; m_held = 1'b0; m_ovr = 1'b0;
    end else begin
      load = 1'b0; drop = 1'b0;
      if (m_pend) m_held = (m_pat != 4'hF);
      if (m_pend && m_pat != 4'hF) begin
        if (!m_valid || out_ready) load = 1'b1; else drop = 1'b1;
      end
      if (load) begin
        m_valid = 1'b1; m_code = hi_low(m_pat); m_err = (cnt_low(m_pat) > 1);
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1; else if (ovr_clr) m_ovr = 1'b0;

      hist.push_back(y_n);
      if (hist.size() > S + 1) void'(hist.pop_front());
      same = (hist.size() == S + 1);
      foreach (hist[i]) if (hist[i] != y_n) same = 1'b0;
      m_pend = 1'b0;
      if (same && y_n != m_acc) begin
        m_pend = 1'b1; m_pat = y_n; m_acc = y_n;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; y_n = 4'hF; out_ready = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({out_valid, out_code, out_err, held, ovr} !== 6'b0)
      $display("FAIL reset_vals got=%b exp=000000", {out_valid, out_code, out_err, held, ovr});
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if ({out_valid, held, ovr} !== 3'b000)
        $display("FAIL idle_quiet cyc=%0d got v/h/o=%b exp=000", i, {out_valid, held, ovr});
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    int nv = 0;
    out_ready = 1'b1; y_n = 4'b1011;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nv++;
      n_chk++;
      if (out_valid !== (i == 5))
        $display("FAIL latency_valid cyc=%0d got=%b exp=%b", i, out_valid, (i == 5));
      else n_pass++;
      if (i == 5) begin
        n_chk++;
        if ({out_code, out_err, held} !== 4'b1001)
          $display("FAIL latency_payload got code=%b err=%b held=%b exp code=10 err=0 held=1",
                   out_code, out_err, held);
        else n_pass++;
      end
    end
    n_chk++;
    if (nv != 1) $display("FAIL single_event got=%0d exp=1", nv); else n_pass++;
  endtask

  task automatic test_glitch();
    int nv = 0;
    logic [2:0] seen = 3'b000;
    y_n = 4'b1101;
    repeat (2) @(negedge clk);
    y_n = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nv++;
    end
    n_chk++;
    if (nv != 0 || held !== 1'b0) $display("FAIL glitch_reject got events=%0d held=%b exp 0/0", nv, held);
    else n_pass++;
    y_n = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin nv++; seen = {out_code, out_err}; end
      n_chk++;
      if ({out_valid, out_code, out_err, held, ovr} !== {m_valid, m_code, m_err, m_held, m_ovr})
        $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i,
                 {out_valid, out_code, out_err, held, ovr}, {m_valid, m_code, m_err, m_held, m_ovr});
      else n_pass++;
    end
    n_chk++;
    if (nv != 1 || seen !== 3'b111) $display("FAIL multi_low got events=%0d code/err=%b exp 1/111", nv, seen);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [3:0] seq[3] = '{4'b1110, 4'b1111, 4'b0111};
    out_ready = 1'b0;
    foreach (seq[k]) begin
      y_n = seq[k];
      repeat (8) @(negedge clk);
    end
    n_chk++;
    if ({out_valid, out_code, out_err, ovr} !== 5'b10001)
      $display("FAIL overrun_hold got v=%b code=%b err=%b ovr=%b exp 1/00/0/1", out_valid, out_code, out_err, ovr);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || ovr !== 1'b1) $display("FAIL overrun_drain got v=%b ovr=%b exp 0/1", out_valid, ovr);
    else n_pass++;
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    n_chk++;
    if (ovr !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", ovr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit hit = 0;
    out_ready = 1'b0; y_n = 4'b1011;
    repeat (8) @(negedge clk);
    y_n = 4'b1101;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (m_pend) hit = 1;
    end
    n_chk++;
    if (!hit) $display("FAIL b2b_timeout got=no accept exp=accept within 12 cycles"); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, out_code, out_err, ovr} !== 5'b10100)
      $display("FAIL b2b_load got v=%b code=%b err=%b ovr=%b exp 1/01/0/0", out_valid, out_code, out_err, ovr);
    else n_pass++;
    hit = 0; y_n = 4'b1110;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (m_pend) hit = 1;
    end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    n_chk++;
    if (!hit || ovr !== 1'b1 || out_code !== 2'b01)
      $display("FAIL set_wins got hit=%0d ovr=%b code=%b exp 1/1/01", hit, ovr, out_code);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    y_n = 4'b1101;
    repeat (2) @(negedge clk);
    y_n = 4'b1110; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    n_chk++;
    if ({out_valid, out_code, out_err, held, ovr} !== 6'b0)
      $display("FAIL mid_reset got=%b exp=000000", {out_valid, out_code, out_err, held, ovr});
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && first < 0) begin
        first = i;
        n_chk++;
        if (out_code !== 2'b00) $display("FAIL reaccept_code got=%b exp=00", out_code); else n_pass++;
      end
    end
    n_chk++;
    if (first != 5) $display("FAIL reaccept_latency got=%0d exp=5", first); else n_pass++;
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 3000) begin
      logic [3:0] p = 4'($urandom_range(0, 15));
      int len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        y_n = p;
        out_ready = ($urandom_range(0, 3) != 0);
        ovr_clr = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 299) == 0);
        @(negedge clk);
        cyc++;
        n_chk++;
        if ({out_valid, out_code, out_err, held, ovr} !== {m_valid, m_code, m_err, m_held, m_ovr})
          $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc,
                   {out_valid, out_code, out_err, held, ovr}, {m_valid, m_code, m_err, m_held, m_ovr});
        else n_pass++;
      end
    end
    rst = 1'b0; ovr_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
